// File: rtl/univ_shift_reg_pkg.sv
// univ_shift_reg_pkg: shared op, direction and state encodings
package univ_shift_reg_pkg;
  localparam logic [1:0] OP_HOLD = 2'b00;
  localparam logic [1:0] OP_ROT = 2'b01;
  localparam logic [1:0] OP_LSH = 2'b10;
  localparam logic [1:0] OP_ASH = 2'b11;
  localparam logic DIR_LEFT = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;
  typedef enum logic {ST_IDLE, ST_RUN} state_t;
endpackage

// File: rtl/univ_shift_reg_if.sv
// univ_shift_reg_if: control and status bundle of the universal shift register
interface univ_shift_reg_if #(
  parameter int WIDTH = 8,
  parameter int AMT_W = $clog2(WIDTH),
  parameter int CNT_W = 8
);
  logic load_n;
  logic [WIDTH-1:0] data_in;
  logic [1:0] op;
  logic dir;
  logic [AMT_W-1:0] amount;
  logic step_en;
  logic run;
  logic [CNT_W-1:0] count_in;
  logic [WIDTH-1:0] q;
  logic serial_out;
  logic busy;
  logic done;
  modport master (
    output load_n, data_in, op, dir, amount, step_en, run, count_in,
    input q, serial_out, busy, done
  );
  modport slave (
    input load_n, data_in, op, dir, amount, step_en, run, count_in,
    output q, serial_out, busy, done
  );
endinterface

// File: rtl/univ_shift_reg_shift_unit.sv
// shift_unit: one combinational rotate/shift step plus the bit moved out
module shift_unit
  import univ_shift_reg_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int AMT_W = $clog2(WIDTH)
) (
  input logic [WIDTH-1:0] q,
  input logic [1:0] op,
  input logic dir,
  input logic [AMT_W-1:0] amount,
  output logic [WIDTH-1:0] nxt,
  output logic out_bit,
  output logic moved
);
  logic [AMT_W-1:0] kr, km1;
  logic [2*WIDTH-1:0] rot_r, rot_l;
  logic signed [WIDTH-1:0] sq;
  logic [WIDTH-1:0] asr, oq_r, oq_l;
  always_comb begin
    kr = AMT_W'(amount % WIDTH);
    km1 = amount - AMT_W'(1);
    rot_r = {q, q} >> kr;
    rot_l = {q, q} << kr;
    sq = q;
    asr = sq >>> amount;
    // the bit that leaves last sits at k-1 from the outgoing edge; beyond it only fill bits leave
    oq_r = q >> km1;
    oq_l = q << km1;
    moved = op != OP_HOLD && amount != '0;
    out_bit = dir == DIR_RIGHT ? oq_r[0] : oq_l[WIDTH-1];
    nxt = !moved ? q
        : op == OP_ROT ? (dir == DIR_RIGHT ? rot_r[WIDTH-1:0] : rot_l[2*WIDTH-1:WIDTH])
        : op == OP_ASH && dir == DIR_RIGHT ? asr
        : dir == DIR_RIGHT ? q >> amount : q << amount;
  end
endmodule

// File: rtl/univ_shift_reg.sv
// univ_shift_reg: register, single-step control and timed auto-run sequencer
module univ_shift_reg
  import univ_shift_reg_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int AMT_W = $clog2(WIDTH),
  parameter int CNT_W = 8,
  parameter int PERIOD = 4
) (
  input logic clk,
  input logic reset,
  univ_shift_reg_if.slave bus
);
  localparam int PRE_W = PERIOD > 1 ? $clog2(PERIOD) : 1;
  state_t state, state_nxt;
  logic [WIDTH-1:0] q, nxt;
  logic serial_out, done, out_bit, moved;
  logic [1:0] op_l;
  logic dir_l;
  logic [AMT_W-1:0] amt_l;
  logic [CNT_W-1:0] cnt;
  logic [PRE_W-1:0] pre;
  logic idle, tick, start, zero_run, step, last;
  shift_unit #(.WIDTH(WIDTH), .AMT_W(AMT_W)) u_shift (
    .q(q),
    .op(idle ? bus.op : op_l),
    .dir(idle ? bus.dir : dir_l),
    .amount(idle ? bus.amount : amt_l),
    .nxt(nxt),
    .out_bit(out_bit),
    .moved(moved)
  );
  always_comb begin
    idle = state == ST_IDLE;
    tick = !idle && pre == PRE_W'(PERIOD - 1);
    start = bus.load_n && idle && bus.run && bus.count_in != '0;
    zero_run = bus.load_n && idle && bus.run && bus.count_in == '0;
    step = bus.load_n && (idle ? bus.step_en && !bus.run : tick);
    last = bus.load_n && tick && cnt == CNT_W'(1);
    state_nxt = !bus.load_n || last ? ST_IDLE : start ? ST_RUN : state;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
      q <= '0;
      serial_out <= 1'b0;
      done <= 1'b0;
      op_l <= OP_HOLD;
      dir_l <= DIR_LEFT;
      amt_l <= '0;
      cnt <= '0;
      pre <= '0;
    end else begin
      state <= state_nxt;
      done <= zero_run || last;
      q <= !bus.load_n ? bus.data_in : step ? nxt : q;
      if (step && moved) serial_out <= out_bit;
      if (start) {op_l, dir_l, amt_l, cnt} <= {bus.op, bus.dir, bus.amount, bus.count_in};
      else if (step && !idle) cnt <= cnt - CNT_W'(1);
      pre <= idle || tick ? '0 : pre + PRE_W'(1);
    end
  end
  assign bus.q = q;
  assign bus.serial_out = serial_out;
  assign bus.busy = !idle;
  assign bus.done = done;
endmodule

// File: tb/tb_univ_shift_reg.sv
// tb_univ_shift_reg: directed vectors with hand-computed results for univ_shift_reg
module tb_univ_shift_reg;
  import univ_shift_reg_pkg::*;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int n_cmp = 0;
  int n_bad = 0;
  univ_shift_reg_if #(.WIDTH(8)) bus ();
  univ_shift_reg #(.WIDTH(8), .PERIOD(4)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic cyc();
    @(negedge clk);
  endtask
  task automatic load(input logic [7:0] v);
    bus.load_n = 1'b0;
    bus.data_in = v;
    cyc();
    bus.load_n = 1'b1;
  endtask
  task automatic step(input logic [1:0] o, input logic d, input logic [2:0] k);
    bus.op = o;
    bus.dir = d;
    bus.amount = k;
    bus.step_en = 1'b1;
    cyc();
    bus.step_en = 1'b0;
  endtask
  logic seen_done;
  initial begin
    bus.load_n = 1'b1;
    bus.data_in = '0;
    bus.op = OP_HOLD;
    bus.dir = DIR_LEFT;
    bus.amount = '0;
    bus.step_en = 1'b0;
    bus.run = 1'b0;
    bus.count_in = '0;
    repeat (2) cyc();
    reset = 1'b1;
    // asynchronous reset landing mid-run, checked before any clock edge
    load(8'hFF);
    chk("load_ff", bus.q, 8'hFF);
    bus.op = OP_ROT;
    bus.amount = 3'd1;
    bus.count_in = 8'd10;
    bus.run = 1'b1;
    cyc();
    bus.run = 1'b0;
    chk("pre_reset_busy", bus.busy, 1);
    repeat (2) cyc();
    #2 reset = 1'b0;
    #1;
    chk("async_q", bus.q, 8'h00);
    chk("async_busy", bus.busy, 0);
    chk("async_done", bus.done, 0);
    chk("async_so", bus.serial_out, 0);
    cyc();
    reset = 1'b1;
    cyc();
    chk("post_reset_q", bus.q, 8'h00);
    load(8'h81);
    step(OP_ROT, DIR_RIGHT, 3'd1);
    chk("rot_r1_q", bus.q, 8'hC0);
    chk("rot_r1_so", bus.serial_out, 1);
    load(8'h90);
    chk("load_holds_so", bus.serial_out, 1);
    step(OP_ASH, DIR_RIGHT, 3'd2);
    chk("ash_r2_q", bus.q, 8'hE4);
    chk("ash_r2_so", bus.serial_out, 0);
    load(8'h81);
    step(OP_LSH, DIR_LEFT, 3'd3);
    chk("lsh_l3_q", bus.q, 8'h08);
    chk("lsh_l3_so", bus.serial_out, 0);
    // auto-run of three rotate-left steps; live controls are changed right after t0
    load(8'h01);
    bus.op = OP_ROT;
    bus.dir = DIR_LEFT;
    bus.amount = 3'd1;
    bus.count_in = 8'd3;
    bus.run = 1'b1;
    cyc();
    bus.run = 1'b0;
    bus.op = OP_LSH;
    bus.dir = DIR_RIGHT;
    bus.amount = 3'd5;
    chk("run3_t0_busy", bus.busy, 1);
    chk("run3_t0_q", bus.q, 8'h01);
    for (int i = 1; i <= 13; i++) begin
      cyc();
      chk($sformatf("run3_q_%0d", i), bus.q, i < 4 ? 8'h01 : i < 8 ? 8'h02 : i < 12 ? 8'h04 : 8'h08);
      chk($sformatf("run3_busy_%0d", i), bus.busy, i < 12 ? 1 : 0);
      chk($sformatf("run3_done_%0d", i), bus.done, i == 12 ? 1 : 0);
    end
    // run aborted by a load at t0+6; step_en during the run is ignored
    load(8'h33);
    bus.op = OP_ROT;
    bus.dir = DIR_LEFT;
    bus.amount = 3'd1;
    bus.count_in = 8'd5;
    bus.run = 1'b1;
    cyc();
    bus.run = 1'b0;
    seen_done = bus.done;
    bus.step_en = 1'b1;
    cyc();
    bus.step_en = 1'b0;
    seen_done |= bus.done;
    chk("run5_step_ignored", bus.q, 8'h33);
    repeat (3) begin
      cyc();
      seen_done |= bus.done;
    end
    chk("run5_first_step", bus.q, 8'h66);
    chk("run5_busy", bus.busy, 1);
    cyc();
    bus.load_n = 1'b0;
    bus.data_in = 8'h5A;
    cyc();
    bus.load_n = 1'b1;
    seen_done |= bus.done;
    chk("abort_q", bus.q, 8'h5A);
    chk("abort_busy", bus.busy, 0);
    repeat (8) begin
      cyc();
      seen_done |= bus.done;
    end
    chk("abort_no_done", seen_done, 0);
    chk("abort_q_stays", bus.q, 8'h5A);
    // zero-length run
    bus.count_in = 8'd0;
    bus.run = 1'b1;
    cyc();
    bus.run = 1'b0;
    chk("run0_done", bus.done, 1);
    chk("run0_busy", bus.busy, 0);
    chk("run0_q", bus.q, 8'h5A);
    cyc();
    chk("run0_done_drop", bus.done, 0);
    load(8'h80);
    step(OP_ASH, DIR_LEFT, 3'd1);
    chk("ash_l1_q", bus.q, 8'h00);
    chk("ash_l1_so", bus.serial_out, 1);
    load(8'h80);
    step(OP_ROT, DIR_RIGHT, 3'd0);
    chk("k0_q", bus.q, 8'h80);
    chk("k0_so_holds", bus.serial_out, 1);
    step(OP_LSH, DIR_RIGHT, 3'd7);
    chk("lsh_r7_q", bus.q, 8'h01);
    chk("lsh_r7_so", bus.serial_out, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/univ_shift_reg.md
Name: univ_shift_reg

Overview:
Parametrised universal shift/rotate register, the successor to the fixed 4-bit rotating register.
- Generic width; rotate, logical shift or arithmetic shift; left or right; multi-bit amount per step.
- Single-step mode, plus an auto-run sequencer that performs N timed steps and raises busy/done.
- Drives LED/pattern displays and feeds serial outputs in lab top levels (SW/KEY in, LEDR out).

Parameters:
WIDTH, 8, register width in bits, at least 2.
AMT_W, $clog2(WIDTH), width of the shift-amount field.
CNT_W, 8, width of the auto-run step count.
PERIOD, 4, clock cycles between auto-run steps, at least 1.

Ports:
clk  in  1  rising-edge clock, the single clock.
reset  in  1  asynchronous active-low reset.
load_n  in  1  active-low parallel load of data_in.
data_in  in  WIDTH  parallel load value.
op  in  2  operation: 00 hold, 01 rotate, 10 logical shift, 11 arithmetic shift.
dir  in  1  direction: 1 right, 0 left.
amount  in  AMT_W  bit positions moved per step.
step_en  in  1  perform one step this cycle (idle only).
run  in  1  start auto-run (idle only).
count_in  in  CNT_W  number of auto-run steps.
q  out  WIDTH  register contents.
serial_out  out  1  last bit shifted or rotated out.
busy  out  1  auto-run in progress.
done  out  1  one-cycle pulse when auto-run completes.

Behaviour:
- Reset low, asynchronous: q=0, serial_out=0, busy=0, done=0, FSM to IDLE, step and prescale counters cleared. Applies mid-run as well, and the run is lost.
- Per-step result for shift amount k:
  - k ≥ WIDTH: rotate uses k mod WIDTH; logical shift gives all zeros; arithmetic right gives all copies of q[WIDTH-1].
  - Rotate moves bits without loss.
  - Logical shift fills with 0.
  - Arithmetic right fills with q[WIDTH-1]. Arithmetic left behaves as logical left.
  - k=0 or op=00 leaves q unchanged, but the step still counts.
- serial_out updates on every step with k≠0 and op≠00:
  - Right: old q[k-1].
  - Left: old q[WIDTH-k].
  - Otherwise it holds.
- Priority at each rising edge: load_n=0 > run (IDLE) > step_en (IDLE).
- load_n=0: q←data_in, serial_out holds.
  - In RUN, the load also aborts: busy←0, no done, FSM to IDLE.
- step_en in IDLE: one step using the live op/dir/amount, applied in the same edge (1-cycle latency).
- FSM states: IDLE, RUN.
  - IDLE→RUN when run=1 and count_in≠0. This edge (t0) latches op/dir/amount/count_in, clears the prescaler and sets busy←1.
  - run=1 with count_in=0: stays IDLE, done=1 for exactly the next cycle, q unchanged.
  - In RUN, a step executes at edges t0+PERIOD, t0+2·PERIOD, … t0+N·PERIOD using the latched controls. Live op/dir/amount changes have no effect.
  - On the edge of the Nth step: q takes its final value, busy←0, done←1 for one cycle, FSM to IDLE.
  - run and step_en are ignored while busy. A new run may be accepted in the cycle where done=1.
- Step counter and prescaler must not wrap: count_in = 2^CNT_W-1 runs exactly that many steps.

Decomposition:
- Shared package holds:
  - op encoding constants OP_HOLD=2'b00, OP_ROT=2'b01, OP_LSH=2'b10, OP_ASH=2'b11.
  - direction constants DIR_LEFT=0, DIR_RIGHT=1.
  - FSM state encoding ST_IDLE, ST_RUN.
- One combinational sub-module, shift_unit: inputs q, op, dir, amount; outputs the next value and the out-bit, parametrised by WIDTH.
- univ_shift_reg holds the register, FSM, step counter and prescaler.

Test Plan (WIDTH=8, PERIOD=4):
1. Reset low mid-activity, then release → q=0x00, busy=0, done=0 immediately, without waiting for a clock edge.
2. Load 0x81, then step with rotate, right, k=1 → q=0xC0, serial_out=1 one cycle after step_en.
3. Load 0x90, then step with arithmetic shift, right, k=2 → q=0xE4, serial_out=0. Load 0x81, then step with logical shift, left, k=3 → q=0x08, serial_out=0.
4. Load 0x01, then run with rotate, left, k=1, count_in=3 at t0 → q=0x02 at t0+4, 0x04 at t0+8, 0x08 at t0+12. busy=1 from t0 to t0+12; done high for the single cycle after t0+12. Changing op mid-run has no effect.
5. Auto-run with count_in=5, load_n=0 with data_in=0x5A at t0+6 → q=0x5A, busy=0, done never asserted. step_en pulsed during the run is ignored.
6. run with count_in=0 → done pulse one cycle, busy stays 0, q unchanged. Logical shift right with k=7 on 0x80 → 0x01, serial_out=0.
